// File: rtl/dino_pkg.sv
// Shared encodings for the player sprite: pose codes and sprite-sheet frame indices.
package dino_pkg;

   localparam int FRAME_W = 2;

   typedef enum logic [1:0] {
      POSE_RUN  = 2'd0,
      POSE_JUMP = 2'd1,
      POSE_DUCK = 2'd2,
      POSE_DEAD = 2'd3
   } pose_e;

   localparam logic [FRAME_W-1:0] FRAME_RUN_A = 2'd0;
   localparam logic [FRAME_W-1:0] FRAME_RUN_B = 2'd1;
   localparam logic [FRAME_W-1:0] FRAME_JUMP  = 2'd0;
   localparam logic [FRAME_W-1:0] FRAME_DUCK  = 2'd2;
   localparam logic [FRAME_W-1:0] FRAME_DEAD  = 2'd3;

   // Fixed frame for the non-animated poses.
   function automatic logic [FRAME_W-1:0] pose_frame(input pose_e p);
      case (p)
         POSE_DUCK: return FRAME_DUCK;
         POSE_DEAD: return FRAME_DEAD;
         default:   return FRAME_JUMP;
      endcase
   endfunction

endpackage

// File: rtl/sprite_anim_render_if.sv
// Sprite ROM bus: the renderer drives the address, the ROM returns one pixel bit.
interface sprite_anim_render_if #(
   parameter int AW = 8
);
   logic [AW-1:0] rom_addr;
   logic          rom_data;

   modport master (output rom_addr, input  rom_data);
   modport slave  (input  rom_addr, output rom_data);
endinterface

// File: rtl/sprite_anim_fsm.sv
// Pose/flip latch sampled on the frame tick, run-animation counter, death blink and frame select.
module sprite_anim_fsm
   import dino_pkg::*;
#(
   parameter int ANIM_DIV  = 4,
   parameter int BLINK_DIV = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_frame_tick,
   input  logic [1:0]         i_pose,
   input  logic               i_flip,
   output logic [FRAME_W-1:0] o_frame,
   output logic               o_flip,
   output logic               o_visible
);

   localparam int AW = $clog2(ANIM_DIV + 1);
   localparam int BW = $clog2(BLINK_DIV + 1);
   localparam logic [AW-1:0] ANIM_LAST  = AW'(ANIM_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   pose_e               pose_q, pose_d;
   logic                flip_q, flip_d;
   logic [AW-1:0]       anim_q, anim_d;
   logic [BW-1:0]       blink_q, blink_d;
   logic                vis_q, vis_d;
   logic [FRAME_W-1:0]  frame_q, frame_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pose_q  <= POSE_RUN;
         flip_q  <= 1'b0;
         anim_q  <= '0;
         blink_q <= '0;
         vis_q   <= 1'b1;
         frame_q <= '0;
      end else begin
         pose_q  <= pose_d;
         flip_q  <= flip_d;
         anim_q  <= anim_d;
         blink_q <= blink_d;
         vis_q   <= vis_d;
         frame_q <= frame_d;
      end
   end

   always_comb begin
      pose_d  = pose_q;
      flip_d  = flip_q;
      anim_d  = anim_q;
      blink_d = blink_q;
      vis_d   = vis_q;
      frame_d = frame_q;
      if (i_frame_tick) begin
         pose_d = pose_e'(i_pose);
         flip_d = i_flip;
         case (pose_d)
            POSE_RUN: begin
               if (pose_q != POSE_RUN) begin
                  anim_d  = '0;
                  frame_d = FRAME_RUN_A;
               end else if (anim_q == ANIM_LAST) begin
                  anim_d  = '0;
                  frame_d = (frame_q == FRAME_RUN_A) ? FRAME_RUN_B : FRAME_RUN_A;
               end else begin
                  anim_d = anim_q + 1'b1;
               end
            end
            default: frame_d = pose_frame(pose_d);
         endcase
         // Blink only advances while DEAD was already latched; entry restarts it visible.
         if (pose_d != POSE_DEAD || pose_q != POSE_DEAD) begin
            blink_d = '0;
            vis_d   = 1'b1;
         end else if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            vis_d   = ~vis_q;
         end else begin
            blink_d = blink_q + 1'b1;
         end
      end
   end

   assign o_frame   = frame_q;
   assign o_flip    = flip_q;
   assign o_visible = vis_q;

endmodule

// File: rtl/sprite_anim_render.sv
// Player sprite renderer: two-stage coordinate pipeline feeding the sprite ROM, plus animation state.
module sprite_anim_render
   import dino_pkg::*;
#(
   parameter int CONV       = 0,
   parameter int W_LOG2     = 3,
   parameter int H_LOG2     = 3,
   parameter int SCALE_LOG2 = 0,
   parameter int X_POS      = 6,
   parameter int Y_BASE     = 50,
   parameter int ANIM_DIV   = 4,
   parameter int BLINK_DIV  = 8,
   parameter int ROM_LAT    = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [9-CONV:0]    i_hpos,
   input  logic [9-CONV:0]    i_vpos,
   input  logic               i_frame_tick,
   input  logic [5:0]         i_ypos,
   input  logic [1:0]         i_pose,
   input  logic               i_flip,
   sprite_anim_render_if.master rom,
   output logic               o_color,
   output logic [FRAME_W-1:0] o_frame
);

   localparam int CW = 10 - CONV;
   localparam int AW = FRAME_W + H_LOG2 + W_LOG2;
   localparam logic [CW:0] X_LIM = (CW + 1)'(2 ** (W_LOG2 + SCALE_LOG2));
   localparam logic [CW:0] Y_LIM = (CW + 1)'(2 ** (H_LOG2 + SCALE_LOG2));

   logic [CW-1:0]      x_off_d, y_off_d;
   logic [W_LOG2-1:0]  col_q, col_d;
   logic [H_LOG2-1:0]  row_q, row_d;
   logic               in1_q, in1_d, in2_q, in_out;
   logic [AW-1:0]      addr_q, addr_d;
   logic               flip, visible;
   logic [FRAME_W-1:0] frame;

   sprite_anim_fsm #(
      .ANIM_DIV  (ANIM_DIV),
      .BLINK_DIV (BLINK_DIV)
   ) u_fsm (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_frame_tick (i_frame_tick),
      .i_pose       (i_pose),
      .i_flip       (i_flip),
      .o_frame      (frame),
      .o_flip       (flip),
      .o_visible    (visible)
   );

   // Stage 1 keeps only the scaled col/row bits; the full offsets are consumed by the box test.
   always_comb begin
      x_off_d = i_hpos - CW'(X_POS);
      y_off_d = i_vpos - {{(CW - 6){i_ypos[5]}}, i_ypos} - CW'(Y_BASE);
      in1_d   = ({1'b0, x_off_d} < X_LIM) && ({1'b0, y_off_d} < Y_LIM);
      col_d   = x_off_d[SCALE_LOG2+W_LOG2-1:SCALE_LOG2];
      row_d   = y_off_d[SCALE_LOG2+H_LOG2-1:SCALE_LOG2];
      addr_d  = {frame, row_q, flip ? ~col_q : col_q};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q  <= '0;
         row_q  <= '0;
         in1_q  <= 1'b0;
         addr_q <= '0;
         in2_q  <= 1'b0;
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         in1_q  <= in1_d;
         addr_q <= addr_d;
         in2_q  <= in1_q;
      end
   end

   if (ROM_LAT == 0) begin : g_lat0
      assign in_out = in2_q;
   end else begin : g_lat1
      logic in3_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) in3_q <= 1'b0;
         else        in3_q <= in2_q;
      end
      assign in_out = in3_q;
   end

   assign rom.rom_addr = addr_q;
   assign o_color      = in_out & rom.rom_data & visible;
   assign o_frame      = frame;

endmodule

// File: tb/tb_sprite_anim_render.sv
// Directed bench: A = defaults with BLINK_DIV=2, B = SCALE_LOG2=1 with a registered ROM.
module tb_sprite_anim_render;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] hpos, vpos;
   logic       frame_tick;
   logic [5:0] ypos;
   logic [1:0] pose;
   logic       flip;
   logic [1:0] rom_mode;   // 0: ROM reads 0, 1: ROM reads 1, 2: address pattern
   logic       color_a, color_b;
   logic [1:0] frame_a, frame_b;
   int         n_cmp = 0;
   int         n_err = 0;
   int         ea, eb;

   sprite_anim_render_if #(.AW(8)) rom_a ();
   sprite_anim_render_if #(.AW(8)) rom_b ();

   always #5 clk = ~clk;

   function automatic logic pat(input logic [7:0] a);
      return ^(a & 8'h6D);
   endfunction

   assign rom_a.rom_data = (rom_mode == 2'd1) | ((rom_mode == 2'd2) & pat(rom_a.rom_addr));
   always @(posedge clk)
      rom_b.rom_data <= (rom_mode == 2'd1) | ((rom_mode == 2'd2) & pat(rom_b.rom_addr));

   sprite_anim_render #(.BLINK_DIV(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .i_hpos(hpos), .i_vpos(vpos), .i_frame_tick(frame_tick),
      .i_ypos(ypos), .i_pose(pose), .i_flip(flip), .rom(rom_a), .o_color(color_a), .o_frame(frame_a)
   );

   sprite_anim_render #(.SCALE_LOG2(1), .ROM_LAT(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .i_hpos(hpos), .i_vpos(vpos), .i_frame_tick(frame_tick),
      .i_ypos(ypos), .i_pose(pose), .i_flip(flip), .rom(rom_b), .o_color(color_b), .o_frame(frame_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic probe(input int h, input int v);
      hpos = 10'(h);
      vpos = 10'(v);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; hpos = '0; vpos = '0; frame_tick = 1'b0;
      ypos = '0; pose = 2'd0; flip = 1'b0; rom_mode = 2'd0;
      #12;
      check("rst_addr_a",  32'(rom_a.rom_addr), 0);
      check("rst_color_a", 32'(color_a), 0);
      check("rst_frame_a", 32'(frame_a), 0);
      check("rst_addr_b",  32'(rom_b.rom_addr), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Streamed scan over the 8x8 box: address and colour appear two cycles later.
      rom_mode = 2'd2;
      for (int i = 0; i <= 64; i++) begin
         if (i < 64) begin
            hpos = 10'(6 + i % 8);
            vpos = 10'(50 + i / 8);
         end else begin
            hpos = '0;
            vpos = '0;
         end
         @(posedge clk); #1;
         if (i >= 1) begin
            ea = i - 1;
            eb = ((i - 1) / 16) * 8 + ((i - 1) % 8) / 2;
            check("t1_addr_a",  32'(rom_a.rom_addr), 32'(ea));
            check("t1_color_a", 32'(color_a), 32'(pat(8'(ea))));
            check("t1_addr_b",  32'(rom_b.rom_addr), 32'(eb));
         end
      end

      // Box edges with the ROM forced to 1.
      rom_mode = 2'd1;
      probe(5, 50);  check("t1_left_a",   32'(color_a), 0); check("t1_left_b",   32'(color_b), 0);
      probe(14, 50); check("t1_right_a",  32'(color_a), 0); check("t1_right_b",  32'(color_b), 1);
      probe(6, 49);  check("t1_top_a",    32'(color_a), 0); check("t1_top_b",    32'(color_b), 0);
      probe(6, 58);  check("t1_bottom_a", 32'(color_a), 0); check("t1_bottom_b", 32'(color_b), 1);

      // Negative height offset moves the box up to vpos 45.
      ypos = 6'h3B;
      probe(6, 44); check("t2_v44_a", 32'(color_a), 0); check("t2_v44_b", 32'(color_b), 0);
      probe(6, 45); check("t2_v45_a", 32'(color_a), 1); check("t2_v45_b", 32'(color_b), 1);
      check("t2_v45_addr_a", 32'(rom_a.rom_addr), 0);
      probe(9, 52); check("t2_addr_a", 32'(rom_a.rom_addr), 59); check("t2_addr_b", 32'(rom_b.rom_addr), 25);
      ypos = '0;

      // Run animation, ANIM_DIV=4.
      probe(6, 50);
      for (int k = 0; k < 9; k++) begin
         tick();
         check("t3_run_frame", 32'(frame_a), (k >= 3 && k <= 6) ? 1 : 0);
      end
      pose = 2'd2;
      repeat (3) @(posedge clk); #1;
      check("t3_duck_hold", 32'(frame_a), 0);
      tick();
      check("t3_duck_frame", 32'(frame_a), 2);
      @(posedge clk); #1;
      check("t3_duck_addr", 32'(rom_a.rom_addr), 128);

      // Death blink, BLINK_DIV=2.
      pose = 2'd3;
      tick();
      check("t4_dead_frame", 32'(frame_a), 3);
      check("t4_dead_entry", 32'(color_a), 1);
      for (int k = 0; k < 6; k++) begin
         tick();
         check("t4_blink", 32'(color_a), (k % 4 == 1 || k % 4 == 2) ? 0 : 1);
      end
      pose = 2'd0;
      tick();
      check("t4_run_frame", 32'(frame_a), 0);
      check("t4_run_color", 32'(color_a), 1);

      // Horizontal flip on A, then scaled box on B.
      flip = 1'b1;
      tick();
      probe(6, 50);  check("t5_flip_l", 32'(rom_a.rom_addr), 7);
      probe(13, 51); check("t5_flip_r", 32'(rom_a.rom_addr), 8);
      flip = 1'b0;
      tick();
      probe(8, 50);  check("t5_a_noflip", 32'(rom_a.rom_addr), 2); check("t5_b_h8", 32'(rom_b.rom_addr), 1);
      probe(7, 50);  check("t5_b_h7", 32'(rom_b.rom_addr), 0);
      probe(21, 50); check("t5_b_h21", 32'(rom_b.rom_addr), 7); check("t5_b_h21_c", 32'(color_b), 1);
      probe(22, 50); check("t5_b_h22_c", 32'(color_b), 0);
      probe(6, 65);  check("t5_b_v65", 32'(rom_b.rom_addr), 56); check("t5_b_v65_c", 32'(color_b), 1);
      probe(6, 66);  check("t5_b_v66_c", 32'(color_b), 0);

      // Reset mid-animation and mid-scan.
      tick();
      tick();
      check("t6_pre_frame", 32'(frame_a), 1);
      pose = 2'd2;
      tick();
      check("t6_pre_duck", 32'(frame_a), 2);
      probe(9, 51);
      check("t6_pre_addr", 32'(rom_a.rom_addr), 139);
      check("t6_pre_color", 32'(color_a), 1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_addr_a",  32'(rom_a.rom_addr), 0);
      check("t6_rst_color_a", 32'(color_a), 0);
      check("t6_rst_frame_a", 32'(frame_a), 0);
      check("t6_rst_color_b", 32'(color_b), 0);
      check("t6_rst_addr_b",  32'(rom_b.rom_addr), 0);
      repeat (2) @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("t6_p1_color_a", 32'(color_a), 0);
      @(posedge clk); #1;
      check("t6_p2_color_a", 32'(color_a), 1);
      check("t6_p2_addr_a",  32'(rom_a.rom_addr), 11);
      check("t6_p2_frame_a", 32'(frame_a), 0);
      check("t6_p2_color_b", 32'(color_b), 0);
      check("t6_p2_addr_b",  32'(rom_b.rom_addr), 1);
      @(posedge clk); #1;
      check("t6_p3_color_b", 32'(color_b), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
